axi_lite_reg_slave: RTL
=======================

AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h5A5A_0001, the value returned by the read-only ID register.
REQ-002 SHALL have the following ports, clock and reset first:
- aclk  in  1  sole clock; all logic on its rising edge.
- areset  in  1  reset; synchronous, active-high.
- AWADDR  in  32  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  write byte strobes; bit n enables byte n.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  32  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- status_in  in  32  live value returned by the STATUS register.
- ctrl_out  out  32  current CTRL register contents.
- ctrl_wr  out  1  one-cycle pulse after any successful CTRL write.

Function
REQ-003 Register map (word index ADDR[3:2]; ADDR[1:0] ignored) SHALL be:
- 0x0 CTRL, read/write.
- 0x4 SCRATCH, read/write.
- 0x8 STATUS, read-only, returns status_in.
- 0xC ID, read-only, returns ID_VALUE.
REQ-004 Any address with ADDR[31:4] != 0 SHALL be out of range.
REQ-005 Response codes SHALL be OKAY = 2'b00 and SLVERR = 2'b10.
REQ-006 Write-path flags SHALL be aw_done and w_done.
- AWREADY = !aw_done && !BVALID.
- WREADY = !w_done && !BVALID.
REQ-007 On an AW handshake the block SHALL latch AWADDR. On a W handshake it SHALL latch WDATA and WSTRB. AW and W SHALL be accepted in either order or in the same cycle.
REQ-008 The write SHALL commit on the clock edge where the second of AW/W completes, using the live bus value for the just-completed channel.
- On that edge: BVALID <= 1, both flags clear.
- Zero cycles between last handshake and commit; BVALID is visible on the following cycle.
REQ-009 Commit to CTRL/SCRATCH SHALL update only the bytes whose WSTRB bit is 1. WSTRB = 0 SHALL still give BRESP = OKAY with no data change.
REQ-010 Commit to STATUS, ID or an out-of-range address SHALL change no register and SHALL set BRESP = SLVERR.
REQ-011 BVALID/BRESP SHALL hold until BVALID && BREADY, then BVALID SHALL deassert on the next edge.
- No new AW/W is accepted while BVALID = 1.
REQ-012 ctrl_wr SHALL be 1 for exactly the cycle after a CTRL commit, regardless of WSTRB value.
REQ-013 Read path:
- ARREADY = !RVALID.
- On an AR handshake, RDATA/RRESP SHALL be registered from register values present that cycle, and RVALID <= 1.
REQ-014 A read from an out-of-range address SHALL return RDATA = 0 and RRESP = SLVERR. All other reads SHALL return RRESP = OKAY.
REQ-015 RDATA/RRESP/RVALID SHALL hold stable until RVALID && RREADY, then RVALID SHALL deassert on the next edge.
- Maximum read throughput is one transaction per 2 cycles.
REQ-016 Read and write paths SHALL be independent. If an AR handshake and a write commit to the same register occur on the same edge, RDATA SHALL return the pre-write value.
REQ-017 Latched address/data SHALL be held while a partner channel is pending, for an unbounded number of cycles.

Reset
REQ-018 While areset = 1 at a rising edge, outputs SHALL take these values:
- AWREADY = WREADY = ARREADY = 0 during reset.
- BVALID = RVALID = 0.
- BRESP = RRESP = 2'b00.
- RDATA = 0.
- CTRL = SCRATCH = 0, ctrl_out = 0.
- ctrl_wr = 0.
- aw_done = w_done = 0.
REQ-019 Reset mid-transaction SHALL discard any latched half-write and any pending B/R response without committing.
- Ready signals SHALL follow REQ-006 and REQ-013 from the first cycle after areset = 0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- AW and W in the same cycle, addr 0x0, data 0x1234_5678, WSTRB 0xF -> next cycle BVALID = 1, BRESP = OKAY, ctrl_out = 0x1234_5678, ctrl_wr = 1 for one cycle.
- W three cycles before AW, addr 0x4, data 0xAABB_CCDD, WSTRB 0x5 over SCRATCH = 0 -> SCRATCH = 0x00BB_00DD, BRESP = OKAY.
- Write to 0xC, or read from 0x20 -> BRESP = SLVERR with ID unchanged; read returns RDATA = 0, RRESP = SLVERR.
- Read 0xC with RREADY held low 5 cycles -> RDATA = 0x5A5A_0001 stable, RVALID stays 1, ARREADY = 0 until the RREADY handshake.
- Read 0x0 on the same edge as a commit of 0xFFFF_FFFF to 0x0 from CTRL = 0 -> RDATA = 0; a following read returns 0xFFFF_FFFF.
- areset asserted after AW handshake but before W -> no commit, BVALID = 0, CTRL/SCRATCH = 0.

Source files
------------

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: write address/data/response and read channels.
interface axi_lite_reg_slave_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave with four word registers: CTRL (rw), SCRATCH (rw), STATUS (ro), ID (ro).
// AW and W are accepted independently and the write commits on the edge completing the pair.
module axi_lite_reg_slave #(
    parameter logic [31:0] ID_VALUE = 32'h5A5A_0001
) (
    input  logic                       aclk,
    input  logic                       areset,
    axi_lite_reg_slave_if.slave        bus,
    input  logic [31:0]                status_in,
    output logic [31:0]                ctrl_out,
    output logic                       ctrl_wr
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_SCRATCH = 2'd1;
    localparam logic [1:0] IDX_STATUS  = 2'd2;
    localparam logic [1:0] IDX_ID      = 2'd3;

    logic          aw_done;
    logic          w_done;
    logic [31:2]   aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          rvalid_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] scratch_q;
    logic          ctrl_wr_q;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic [31:2]   wr_addr;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          wr_in_range;
    logic          wr_writable;
    logic [DW-1:0] wr_merged;
    logic          rd_in_range;
    logic [DW-1:0] rd_word;
    logic          unused_addr_bits;

    // Ready signals are forced low while reset is held.
    assign bus.AWREADY = !areset && !aw_done && !bvalid_q;
    assign bus.WREADY  = !areset && !w_done  && !bvalid_q;
    assign bus.ARREADY = !areset && !rvalid_q;

    assign aw_hs  = bus.AWVALID && bus.AWREADY;
    assign w_hs   = bus.WVALID  && bus.WREADY;
    assign ar_hs  = bus.ARVALID && bus.ARREADY;
    assign commit = (aw_done || aw_hs) && (w_done || w_hs);

    // The channel completing on this edge supplies its live bus value.
    assign wr_addr = aw_hs ? bus.AWADDR[31:2] : aw_addr_q;
    assign wr_data = w_hs  ? bus.WDATA        : w_data_q;
    assign wr_strb = w_hs  ? bus.WSTRB        : w_strb_q;

    assign wr_in_range = (wr_addr[31:4] == 28'd0);
    assign wr_writable = wr_in_range &&
                         ((wr_addr[3:2] == IDX_CTRL) || (wr_addr[3:2] == IDX_SCRATCH));

    always_comb begin
        wr_merged = (wr_addr[3:2] == IDX_CTRL) ? ctrl_q : scratch_q;
        for (int b = 0; b < int'(SW); b++) begin
            if (wr_strb[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    assign rd_in_range = (bus.ARADDR[31:4] == 28'd0);

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            case (bus.ARADDR[3:2])
                IDX_CTRL:    rd_word = ctrl_q;
                IDX_SCRATCH: rd_word = scratch_q;
                IDX_STATUS:  rd_word = status_in;
                IDX_ID:      rd_word = ID_VALUE;
                default:     rd_word = '0;
            endcase
        end
    end

    assign unused_addr_bits = ^{bus.AWADDR[1:0], bus.ARADDR[1:0]};

    // Write channel acceptance, commit and response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            ctrl_q    <= '0;
            scratch_q <= '0;
            ctrl_wr_q <= 1'b0;
        end else begin
            ctrl_wr_q <= 1'b0;
            if (commit) begin
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_writable ? RESP_OKAY : RESP_SLVERR;
                if (wr_writable && (wr_addr[3:2] == IDX_CTRL)) begin
                    ctrl_q    <= wr_merged;
                    ctrl_wr_q <= 1'b1;
                end
                if (wr_writable && (wr_addr[3:2] == IDX_SCRATCH)) begin
                    scratch_q <= wr_merged;
                end
            end else begin
                if (aw_hs) begin
                    aw_done   <= 1'b1;
                    aw_addr_q <= bus.AWADDR[31:2];
                end
                if (w_hs) begin
                    w_done   <= 1'b1;
                    w_data_q <= bus.WDATA;
                    w_strb_q <= bus.WSTRB;
                end
                if (bvalid_q && bus.BREADY) begin
                    bvalid_q <= 1'b0;
                end
            end
        end
    end

    // Read channel: data captured on the AR edge, held until accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_word;
        end else if (rvalid_q && bus.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign bus.BVALID = bvalid_q;
    assign bus.BRESP  = bresp_q;
    assign bus.RVALID = rvalid_q;
    assign bus.RRESP  = rresp_q;
    assign bus.RDATA  = rdata_q;
    assign ctrl_out   = ctrl_q;
    assign ctrl_wr    = ctrl_wr_q;

endmodule
